hilo_muldiv: RTL and testbench

// - E-stage multiply/divide unit with private HI/LO registers; consumes start/alupro_op from the decode controller.
// - Executes mult, multu, div, divu and msub over multiple cycles.
// - Also handles mthi, mtlo, mfhi and mflo.
// - Exposes busy so D-stage stall logic can hold any HI/LO-using instruction while an operation is in flight.

---
 rtl/hilo_muldiv_pkg.sv | 41 ++++
 rtl/md_counter.sv | 30 +++
 rtl/hilo_muldiv.sv | 147 ++++++++++++++
 tb/tb_hilo_muldiv.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: op encodings, FSM state type and op classification helpers
// Latency: n/a (types and pure functions only)
// Backpressure: n/a
// Contents: op_e (alupro_op encodings), state_e, is_launch(), is_div()
package hilo_muldiv_pkg;

   // alupro_op encodings shared with the decode controller and stall unit.
   typedef enum logic [3:0] {
      OP_NONE  = 4'b0000,
      OP_MULT  = 4'b0001,
      OP_MULTU = 4'b0010,
      OP_DIV   = 4'b0011,
      OP_DIVU  = 4'b0100,
      OP_MTLO  = 4'b0101,
      OP_MTHI  = 4'b0110,
      OP_MFLO  = 4'b0111,
      OP_MFHI  = 4'b1000,
      OP_MSUB  = 4'b1001
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;

   // Ops that occupy the unit for multiple cycles when started.
   function automatic logic is_launch(input logic [3:0] op);
      case (op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MSUB: is_launch = 1'b1;
         default:                                    is_launch = 1'b0;
      endcase
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      is_div = (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/md_counter.sv
// md_counter: loadable down-counter that times a multi-cycle HI/LO operation
// Latency: load takes effect next cycle; done is combinational from the count
// Backpressure: none; the owner must only load while the count is zero
// Ports: clk, reset (async high), load, n (load value), done (count==1)
module md_counter #(
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] n,
   output logic          done
);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= n;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   // A count of 1 can only exist while running, so this marks the last busy cycle.
   assign done = (count == CW'(1));

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: E-stage multiply/divide unit owning HI/LO (mult/multu/div/divu/msub, mthi/mtlo, mfhi/mflo)
// Latency: launch ops busy for MULT_CYCLES/DIV_CYCLES, result visible the cycle after busy falls; mf_out combinational
// Backpressure: busy is a registered stall request; start and mthi/mtlo are ignored while busy
// Ports: clk, reset (async high), start, op[3:0], A, B -> busy, HI, LO, mf_out
module hilo_muldiv
   import hilo_muldiv_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic [WIDTH-1:0] mf_out
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;
   localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

   state_e state_q, state_d;
   logic   launch;
   logic   done;
   logic   commit;

   logic [2*WIDTH-1:0] pend_q, pend_d;
   op_e                kind_q;
   logic               dz_q;

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   assign launch = (state_q == ST_IDLE) && start && is_launch(op);
   assign commit = (state_q == ST_RUN) && done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (launch) state_d = ST_RUN;
         ST_RUN:  if (done)   state_d = ST_IDLE;
         default:             state_d = ST_IDLE;
      endcase
   end

   // Decoded straight from the state flop: never depends on start.
   assign busy = (state_q == ST_RUN);

   md_counter #(.CW(CW)) u_counter (
      .clk   (clk),
      .reset (reset),
      .load  (launch),
      .n     (is_div(op) ? DIV_N : MULT_N),
      .done  (done)
   );

   // ------------------------------------------------------------------
   // Arithmetic, evaluated on the launch cycle operands
   // ------------------------------------------------------------------
   logic [2*WIDTH-1:0] prod_s, prod_u;
   logic               sgn, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, quo, rem;

   always_comb begin
      // Sign/zero extension to 2*WIDTH makes the truncated product exact.
      prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
      prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

      // Signed divide on magnitudes: the most negative dividend keeps its
      // bit pattern as an unsigned magnitude, so MIN / -1 lands on MIN, rem 0.
      sgn   = (op == OP_DIV);
      a_neg = sgn && A[WIDTH-1];
      b_neg = sgn && B[WIDTH-1];
      a_mag = a_neg ? -A : A;
      b_mag = b_neg ? -B : B;
      q_mag = '0;
      r_mag = '0;
      if (b_mag != '0) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
      end
      quo = (a_neg ^ b_neg) ? -q_mag : q_mag;
      rem = a_neg ? -r_mag : r_mag;

      pend_d = '0;
      case (op)
         OP_MULT, OP_MSUB: pend_d = prod_s;
         OP_MULTU:         pend_d = prod_u;
         OP_DIV, OP_DIVU:  pend_d = {rem, quo};
         default:          pend_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q <= '0;
         kind_q <= OP_NONE;
         dz_q   <= 1'b0;
      end else if (launch) begin
         pend_q <= pend_d;
         kind_q <= op_e'(op);
         dz_q   <= (B == '0);
      end
   end

   // ------------------------------------------------------------------
   // HI/LO registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         HI <= '0;
         LO <= '0;
      end else if (commit) begin
         case (kind_q)
            OP_MULT, OP_MULTU: {HI, LO} <= pend_q;
            // HI/LO are frozen while busy, so subtracting here equals
            // subtracting from the values present at launch.
            OP_MSUB:           {HI, LO} <= {HI, LO} - pend_q;
            OP_DIV, OP_DIVU:   if (!dz_q) {HI, LO} <= pend_q;
            default: ;
         endcase
      end else if (!busy) begin
         if (op == OP_MTHI)      HI <= A;
         else if (op == OP_MTLO) LO <= A;
      end
   end

   // Registered HI/LO only; a pending result is never forwarded.
   always_comb begin
      mf_out = '0;
      if (op == OP_MFHI)      mf_out = HI;
      else if (op == OP_MFLO) mf_out = LO;
   end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed + randomized bench for hilo_muldiv against a behavioural model
// Latency: model commits the op result after the configured busy window
// Backpressure: exercises start and mthi/mtlo while busy
module tb_hilo_muldiv;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        busy;
   logic [31:0] HI, LO, mf_out;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   hilo_muldiv #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .A      (A),
      .B      (B),
      .busy   (busy),
      .HI     (HI),
      .LO     (LO),
      .mf_out (mf_out)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
   logic [3:0]  m_kind = '0;
   int          m_left = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hi = '0; m_lo = '0; m_left = 0; m_kind = '0; m_a = '0; m_b = '0;
   endtask

   task automatic model_commit();
      longint          p, q, r;
      longint unsigned pu;
      p = longint'($signed(m_a)) * longint'($signed(m_b));
      case (m_kind)
         4'd1: {m_hi, m_lo} = p;
         4'd2: begin pu = {32'd0, m_a} * {32'd0, m_b}; {m_hi, m_lo} = pu; end
         4'd9: {m_hi, m_lo} = {m_hi, m_lo} - p;
         4'd3: if (m_b != 0) begin
                  q = longint'($signed(m_a)) / longint'($signed(m_b));
                  r = longint'($signed(m_a)) % longint'($signed(m_b));
                  m_lo = q[31:0];
                  m_hi = r[31:0];
               end
         4'd4: if (m_b != 0) begin m_lo = m_a / m_b; m_hi = m_a % m_b; end
         default: ;
      endcase
   endtask

   // Called right after each posedge with the inputs that edge saw.
   task automatic model_edge();
      if (reset) return;
      if (m_left > 0) begin
         if (m_left == 1) model_commit();
         m_left--;
      end else if (start && (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd9})) begin
         m_kind = op; m_a = A; m_b = B;
         m_left = (op == 4'd3 || op == 4'd4) ? 10 : 5;
      end else if (op == 4'd6) begin
         m_hi = A;
      end else if (op == 4'd5) begin
         m_lo = A;
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
         chk("HI", HI, m_hi);
         chk("LO", LO, m_lo);
         chk("mf_out", mf_out, (op == 4'd8) ? m_hi : (op == 4'd7) ? m_lo : 32'd0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input logic s, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      start = s; op = o; A = a; B = b;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, output int nb);
      cyc(1'b1, o, a, b);
      nb = 0;
      while (busy && nb < 50) begin
         nb++;
         cyc(1'b0, 4'd0, 32'd0, 32'd0);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         n++;
         cyc(1'b0, 4'd0, 32'd0, 32'd0);
      end
      chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return $urandom_range(1, 9);
         default: return $urandom;
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int nb;
      logic [3:0] launch_ops [5];
      launch_ops[0] = 4'd1; launch_ops[1] = 4'd2; launch_ops[2] = 4'd3;
      launch_ops[3] = 4'd4; launch_ops[4] = 4'd9;

      #2;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_HI", HI, 32'd0);
      chk("rst_LO", LO, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      cmp_en = 1'b1;

      // signed mult -3 * 5
      run_op(4'd1, 32'hFFFF_FFFD, 32'd5, nb);
      chk("mult_busy_cycles", nb, 32'd5);
      chk("mult_HI", HI, 32'hFFFF_FFFF);
      chk("mult_LO", LO, 32'hFFFF_FFF1);

      // divu 7 / 2
      run_op(4'd4, 32'd7, 32'd2, nb);
      chk("divu_busy_cycles", nb, 32'd10);
      chk("divu_LO", LO, 32'd3);
      chk("divu_HI", HI, 32'd1);

      // div -7 / 2
      run_op(4'd3, 32'hFFFF_FFF9, 32'd2, nb);
      chk("div_LO", LO, 32'hFFFF_FFFD);
      chk("div_HI", HI, 32'hFFFF_FFFF);

      // div by zero leaves HI/LO alone
      run_op(4'd3, 32'd5, 32'd0, nb);
      chk("divz_busy_cycles", nb, 32'd10);
      chk("divz_LO", LO, 32'hFFFF_FFFD);
      chk("divz_HI", HI, 32'hFFFF_FFFF);

      // msub from {0,10} and from {0,0}
      cyc(1'b0, 4'd6, 32'd0, 32'd0);
      cyc(1'b0, 4'd5, 32'd10, 32'd0);
      run_op(4'd9, 32'd2, 32'd3, nb);
      chk("msub_busy_cycles", nb, 32'd5);
      chk("msub1_HI", HI, 32'd0);
      chk("msub1_LO", LO, 32'd4);
      cyc(1'b0, 4'd5, 32'd0, 32'd0);
      run_op(4'd9, 32'd2, 32'd3, nb);
      chk("msub2_HI", HI, 32'hFFFF_FFFF);
      chk("msub2_LO", LO, 32'hFFFF_FFFA);

      // mthi and a stray start during busy are both ignored
      cyc(1'b1, 4'd1, 32'd2, 32'd3);
      cyc(1'b0, 4'd6, 32'h1234, 32'd0);
      chk("mthi_busy_HI", HI, 32'hFFFF_FFFF);
      cyc(1'b1, 4'd3, 32'd9, 32'd9);
      wait_idle();
      chk("mult2_HI", HI, 32'd0);
      chk("mult2_LO", LO, 32'd6);
      cyc(1'b0, 4'd6, 32'h1234, 32'd0);
      cyc(1'b0, 4'd8, 32'd0, 32'd0);
      chk("mfhi", mf_out, 32'h1234);
      cyc(1'b0, 4'd7, 32'd0, 32'd0);
      chk("mflo", mf_out, 32'd6);

      // overflow corner of signed divide
      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb);
      chk("divmin_LO", LO, 32'h8000_0000);
      chk("divmin_HI", HI, 32'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) < 4)
            cyc(1'b1, launch_ops[$urandom_range(0, 4)], rand_operand(), rand_operand());
         else
            cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_operand(), rand_operand());
      end
      wait_idle();

      // reset in busy cycle 3 of a div
      cyc(1'b0, 4'd6, 32'hAAAA_5555, 32'd0);
      cyc(1'b1, 4'd3, 32'd100, 32'd7);
      cyc(1'b0, 4'd0, 32'd0, 32'd0);
      cyc(1'b0, 4'd0, 32'd0, 32'd0);
      chk("pre_reset_busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_HI", HI, 32'd0);
      chk("midrst_LO", LO, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (12) cyc(1'b0, 4'd0, 32'd0, 32'd0);
      chk("postrst_busy", {31'd0, busy}, 32'd0);
      chk("postrst_HI", HI, 32'd0);
      chk("postrst_LO", LO, 32'd0);

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
